fp_mul_pipe: RTL and testbench

Three-stage pipelined IEEE-754 single-precision multiplier for the matrix-multiplier datapath. It sits directly upstream of IEEE_SP_FP_ADDER: each row/column element pair is multiplied here, and the product stream feeds the adder for dot-product accumulation. A per-operand tag travels with the data so the downstream accumulator can tell which matrix element each product belongs to.

---
 rtl/fp_mul_pipe.sv | 191 +++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 single-precision multiplier with a sideband tag.
// Stages: unpack/classify, significand multiply, normalise/round(RNE)/pack.
module fp_mul_pipe #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf,
    output logic             unf,
    output logic             inv
);

    logic en;
    assign en = ~stall;

    // Stage 1: unpack and classify
    logic [7:0]        ea, eb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              s1_valid_d, s1_sign_d, s1_inv_d, s1_inf_d, s1_zero_d;
    logic signed [9:0] s1_es_d;
    logic [23:0]       s1_ma_d, s1_mb_d;
    logic [TAG_W-1:0]  s1_tag_d;

    logic              s1_valid_q, s1_sign_q, s1_inv_q, s1_inf_q, s1_zero_q;
    logic signed [9:0] s1_es_q;
    logic [23:0]       s1_ma_q, s1_mb_q;
    logic [TAG_W-1:0]  s1_tag_q;

    always_comb begin
        ea         = a[30:23];
        eb         = b[30:23];
        a_zero     = (ea == 8'd0);
        b_zero     = (eb == 8'd0);
        a_inf      = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf      = (eb == 8'hFF) && (b[22:0] == 23'd0);
        a_nan      = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan      = (eb == 8'hFF) && (b[22:0] != 23'd0);
        s1_valid_d = in_valid;
        s1_sign_d  = a[31] ^ b[31];
        s1_es_d    = $signed({2'b00, ea} + {2'b00, eb} - 10'd127);
        s1_ma_d    = {1'b1, a[22:0]};
        s1_mb_d    = {1'b1, b[22:0]};
        s1_tag_d   = in_tag;
        s1_inv_d   = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        s1_inf_d   = (a_inf | b_inf) & ~s1_inv_d;
        s1_zero_d  = (a_zero | b_zero) & ~s1_inv_d & ~s1_inf_d;
    end

    // Stage 2: significand product
    logic              s2_valid_q, s2_sign_q, s2_inv_q, s2_inf_q, s2_zero_q;
    logic signed [9:0] s2_es_q;
    logic [47:0]       s2_prod_q, s2_prod_d;
    logic [TAG_W-1:0]  s2_tag_q;

    always_comb begin
        s2_prod_d = 48'(s1_ma_q) * 48'(s1_mb_q);
    end

    // Stage 3: normalise, round to nearest even, pack
    logic [23:0]       mant;
    logic              guard, sticky, rnd;
    logic [24:0]       mant_r;
    logic [22:0]       frac;
    logic signed [9:0] exp_n;
    logic              out_valid_d, ovf_d, unf_d, inv_d;
    logic [31:0]       result_d;
    logic [TAG_W-1:0]  out_tag_d;

    logic              out_valid_q, ovf_q, unf_q, inv_q;
    logic [31:0]       result_q;
    logic [TAG_W-1:0]  out_tag_q;

    always_comb begin
        if (s2_prod_q[47]) begin
            mant   = s2_prod_q[47:24];
            guard  = s2_prod_q[23];
            sticky = |s2_prod_q[22:0];
            exp_n  = s2_es_q + 10'sd1;
        end else begin
            mant   = s2_prod_q[46:23];
            guard  = s2_prod_q[22];
            sticky = |s2_prod_q[21:0];
            exp_n  = s2_es_q;
        end
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + 25'(rnd);
        if (mant_r[24]) begin
            exp_n = exp_n + 10'sd1;
            frac  = mant_r[23:1];
        end else begin
            frac  = mant_r[22:0];
        end

        out_valid_d = s2_valid_q;
        result_d    = result_q;
        out_tag_d   = out_tag_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inv_d       = inv_q;
        if (s2_valid_q) begin
            out_tag_d = s2_tag_q;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            inv_d     = 1'b0;
            if (s2_inv_q) begin
                result_d = 32'h7FC0_0000;
                inv_d    = 1'b1;
            end else if (s2_inf_q) begin
                result_d = {s2_sign_q, 8'hFF, 23'd0};
            end else if (s2_zero_q) begin
                result_d = {s2_sign_q, 31'd0};
            end else if (exp_n >= 10'sd255) begin
                result_d = {s2_sign_q, 8'hFF, 23'd0};
                ovf_d    = 1'b1;
            end else if (exp_n <= 10'sd0) begin
                result_d = {s2_sign_q, 31'd0};
                unf_d    = 1'b1;
            end else begin
                result_d = {s2_sign_q, exp_n[7:0], frac};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_inv_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_es_q     <= '0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_inv_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_es_q     <= '0;
            s2_prod_q   <= '0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_inv_q    <= s1_inv_d;
            s1_inf_q    <= s1_inf_d;
            s1_zero_q   <= s1_zero_d;
            s1_es_q     <= s1_es_d;
            s1_ma_q     <= s1_ma_d;
            s1_mb_q     <= s1_mb_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_inv_q    <= s1_inv_q;
            s2_inf_q    <= s1_inf_q;
            s2_zero_q   <= s1_zero_q;
            s2_es_q     <= s1_es_q;
            s2_prod_q   <= s2_prod_d;
            s2_tag_q    <= s1_tag_q;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            out_tag_q   <= out_tag_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inv_q       <= inv_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign inv       = inv_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: the driver queues hand-computed expectations,
// a negedge monitor pops and compares each emitted product.
module tb_fp_mul_pipe;

    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             in_valid;
    logic [31:0]      a, b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic [31:0]      result;
    logic [TAG_W-1:0] out_tag;
    logic             ovf, unf, inv;

    fp_mul_pipe #(.TAG_W(TAG_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .result   (result),
        .out_tag  (out_tag),
        .ovf      (ovf),
        .unf      (unf),
        .inv      (inv)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic             unf;
        logic             inv;
    } exp_t;

    exp_t q[$];
    exp_t last_e;
    logic have_last = 1'b0;
    logic fire = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // An output is new only after an edge on which the pipeline was enabled.
    always @(posedge clk) fire <= ~stall;

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid) begin
            if (fire) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%08h tag %0d, expected none",
                             result, out_tag);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    chk("flags", {29'd0, ovf, unf, inv}, {29'd0, e.ovf, e.unf, e.inv});
                    last_e    = e;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                chk("stall_hold_result", result, last_e.res);
                chk("stall_hold_tag", 32'(out_tag), 32'(last_e.tag));
            end
        end
    end

    // Drive one pair; optionally hold stall for n_stall cycles while it is presented.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] tg,
                        input logic [31:0] er, input logic eo, input logic eu, input logic ei,
                        input int n_stall);
        exp_t e;
        @(negedge clk);
        a        = av;
        b        = bv;
        in_tag   = tg;
        in_valid = 1'b1;
        stall    = (n_stall > 0);
        e.res = er; e.tag = tg; e.ovf = eo; e.unf = eu; e.inv = ei;
        q.push_back(e);
        repeat (n_stall) begin
            @(posedge clk);
            @(negedge clk);
        end
        stall = 1'b0;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'hDEAD_BEEF;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
    endtask

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        in_tag   = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;

        // 99 * 178 with latency check
        send(32'h42C60000, 32'h43320000, 4'd1, 32'h4689AC00, 0, 0, 0, 0);
        idle();
        chk("lat_edge0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge2", 32'(out_valid), 32'd1);
        drain();

        // back-to-back, including RNE and signed zero
        send(32'h42C20000, 32'hC29E0000, 4'd2, 32'hC5EF7800, 0, 0, 0, 0);
        send(32'h00000000, 32'hC2E20000, 4'd3, 32'h80000000, 0, 0, 0, 0);
        send(32'h3F800001, 32'h3F800001, 4'd4, 32'h3F800002, 0, 0, 0, 0);
        // overflow, underflow, invalid, inf*finite, NaN
        send(32'h7F000000, 32'h7F000000, 4'd5, 32'h7F800000, 1, 0, 0, 0);
        send(32'h00800000, 32'h00800000, 4'd6, 32'h00000000, 0, 1, 0, 0);
        send(32'h7F800000, 32'h00000000, 4'd7, 32'h7FC00000, 0, 0, 1, 0);
        send(32'hFF800000, 32'h40000000, 4'd8, 32'hFF800000, 0, 0, 0, 0);
        send(32'h7FC00001, 32'h3F800000, 4'd9, 32'h7FC00000, 0, 0, 1, 0);
        // 1.5 * 1.5 = 2.25 exercises the product[47] normalisation
        send(32'h3FC00000, 32'h3FC00000, 4'd10, 32'h40100000, 0, 0, 0, 0);
        idle();
        drain();

        // stream with a 3-cycle stall while pair 3 is presented
        send(32'h40000000, 32'h40400000, 4'd0, 32'h40C00000, 0, 0, 0, 0);
        send(32'h40800000, 32'h40A00000, 4'd1, 32'h41A00000, 0, 0, 0, 0);
        send(32'hBF800000, 32'h41000000, 4'd2, 32'hC1000000, 0, 0, 0, 0);
        send(32'h41200000, 32'h41200000, 4'd3, 32'h42C80000, 0, 0, 0, 3);
        idle();
        drain();

        // async reset with three products in flight
        send(32'h3F800000, 32'h3F800000, 4'd11, 32'h3F800000, 0, 0, 0, 0);
        send(32'h40000000, 32'h40000000, 4'd12, 32'h40800000, 0, 0, 0, 0);
        send(32'h40400000, 32'h40400000, 4'd13, 32'h41100000, 0, 0, 0, 0);
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_result", result, 32'd0);
        q.delete();
        have_last = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_reset_quiet", 32'(out_valid), 32'd0);

        send(32'h42C60000, 32'h43320000, 4'd14, 32'h4689AC00, 0, 0, 0, 0);
        idle();
        drain();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
